alu_seq_exec: RTL and testbench
===============================

# alu_seq_exec

Sequential execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and computes the result over one or more cycles. It accepts operands through a valid/ready handshake, performs single-cycle arithmetic and logic operations, and performs shifts iteratively at one bit per cycle. It sits between operand fetch and writeback in the multi-cycle datapath variant of the RV32 core.

## Interface

Parameters:
- XLEN, 32, operand and result width; power of two, minimum 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands and code are presented.
- in_ready  out  1  unit accepts a new operation. Defined as (state==IDLE) && !rst.
- alu_control  in  4  operation code, sampled on input handshake.
- op_a  in  XLEN  first operand, sampled on input handshake.
- op_b  in  XLEN  second operand, or shift amount source, sampled on input handshake.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  registered; set when the accepted code is undefined.

## Operation

- Code map:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT (signed), 1001 SLTU (unsigned).
  - 1010–1111 undefined.
- Arithmetic is modulo 2^XLEN, with no carry or overflow output. SLT and SLTU return 1 or 0 zero-extended to XLEN bits.
- Shift amount is op_b[log2(XLEN)-1:0]. Upper bits of op_b are ignored.
- Undefined code: result = 0, illegal = 1, zero = 1.
- State machine (IDLE, SHIFT, DONE):
  - **IDLE**: on in_valid && in_ready, latch operands and code.
    - Non-shift op: compute result, go to DONE.
    - Shift op with shamt == 0: result = op_a, go to DONE.
    - Shift op with shamt > 0: load op_a into the shift register, load the counter with shamt, go to SHIFT.
  - **SHIFT**: each cycle, shift one bit and decrement the counter.
    - SLL inserts 0 at bit 0.
    - SRL inserts 0 at the MSB.
    - SRA replicates the MSB.
    - When the counter reaches 1 on this cycle, go to DONE with the final value.
  - **DONE**: out_valid = 1. result, zero and illegal are held stable. On out_ready, go to IDLE.
- No combinational path from in_* to out_*, or from out_ready to in_ready.
- in_valid while not in IDLE is ignored; the operation is not accepted.
- Reset values: state IDLE, out_valid 0, result 0, zero 0, illegal 0, shift counter 0. in_ready is 0 while rst is high and 1 in the first cycle after.
- Reset asserted mid-SHIFT or in DONE: the operation is discarded with no output handshake, and the unit returns to IDLE next edge.

## Timing

- Latency is measured from the input-handshake edge to the first cycle out_valid is high.
  - Non-shift op, or shift with shamt 0: 1 cycle.
  - Shift with shamt = N > 0: 1 + N cycles (maximum 1 + XLEN-1).
- Throughput: one operation per two cycles at best, because in_ready is low in DONE.
- Output handshake completes on the edge where out_valid && out_ready. in_ready rises the cycle after.
- out_ready held low: out_valid, result, zero and illegal stay unchanged indefinitely.

## Test plan

1. Reset, then ADD op_a=5, op_b=7 with out_ready=1 → out_valid 1 cycle after accept, result=12, zero=0, illegal=0. in_ready returns to 1 the following cycle.
2. SUB op_a=op_b=0x1234 → result=0, zero=1. Then SLT op_a=0xFFFFFFFF, op_b=1 → result=1. Then SLTU with the same operands → result=0.
3. SRA op_a=0x80000000, op_b=0xFFFFFF04 (shamt 4) → out_valid exactly 5 cycles after accept, result=0xF8000000, in_ready low throughout. SLL 0x1 by 31 → 0x80000000 after 32 cycles. SRL 0x80000000 by 0 → 0x80000000 after 1 cycle.
4. Backpressure: ADD 1+1 with out_ready low for 3 cycles → result=2 held, out_valid held, in_ready 0. A second in_valid during this window is not accepted. Raise out_ready → handshake, then the second op is accepted.
5. Assert rst for 1 cycle during SLL by 20, at the 10th shift cycle → out_valid never rises for that op. out_valid=0 and result=0 after reset, and in_ready=1 the next cycle.
6. Codes 1010 and 1111 with op_a=op_b=0xFFFFFFFF → result=0, zero=1, illegal=1 after 1 cycle. A following legal XOR 0xF0F0F0F0^0x0F0F0F0F → result 0xFFFFFFFF, illegal=0.

Source files
------------

// File: rtl/alu_seq_exec.sv
`timescale 1ns/1ps
// Multi-cycle ALU: logic/arith ops finish in one cycle; shifts step one bit per cycle.
// Handshake in via in_valid/in_ready, result held in DONE until out_ready.
module alu_seq_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            zero_q, zero_d;
  logic            ill_q, ill_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] shifted;
  logic            lt_s, lt_u;

  assign shamt     = op_b[SW-1:0];
  assign lt_s      = $signed(op_a) < $signed(op_b);
  assign lt_u      = op_a < op_b;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;

  // res_q doubles as the shift register while in SHIFT
  always_comb begin
    shifted = {res_q[XLEN-2:0], 1'b0};
    if (code_q == OP_SRL)
      shifted = {1'b0, res_q[XLEN-1:1]};
    else if (code_q == OP_SRA)
      shifted = {res_q[XLEN-1], res_q[XLEN-1:1]};
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d  = alu_control;
          ill_d   = 1'b0;
          state_d = DONE;
          case (alu_control)
            OP_ADD:  res_d = op_a + op_b;
            OP_SUB:  res_d = op_a - op_b;
            OP_AND:  res_d = op_a & op_b;
            OP_OR:   res_d = op_a | op_b;
            OP_XOR:  res_d = op_a ^ op_b;
            OP_SLL, OP_SRL, OP_SRA: begin
              res_d = op_a;
              cnt_d = shamt;
              if (shamt != '0) state_d = SHIFT;
            end
            OP_SLT:  res_d = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: res_d = {{(XLEN-1){1'b0}}, lt_u};
            default: begin
              res_d = '0;
              ill_d = 1'b1;
            end
          endcase
          zero_d = (res_d == '0);
        end
      end
      SHIFT: begin
        res_d  = shifted;
        zero_d = (shifted == '0);
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_seq_exec: directed scenarios then random ops with random backpressure.
module tb_alu_seq_exec;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  alu_seq_exec #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    longint      t_acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   ordy_mode = 1;
  bit   first_seen = 0;
  bit   t4_done = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  function automatic exp_t model(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    exp_t e;
    int   sh;
    sh      = int'(b[4:0]);
    e.ill   = 1'b0;
    e.lat   = 1;
    e.t_acc = 0;
    case (c)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << sh;
      4'd6: e.res = a >> sh;
      4'd7: e.res = 32'($signed(a) >>> sh);
      4'd8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    if ((c inside {4'd5, 4'd6, 4'd7}) && sh != 0) e.lat = 1 + sh;
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Present an op and hold it until the DUT takes it; expectation queued at the accept edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   rdy;
    bit   done;
    done        = 1'b0;
    alu_control = c;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        done    = 1'b1;
        e       = model(c, a, b);
        e.t_acc = longint'($time);
        sb.push_back(e);
      end
    end
    #1 in_valid = 1'b0;
    chk("accept", 32'(done), 32'd1);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares held outputs against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (rst) begin
      first_seen = 1'b0;
    end else begin
      if (sb.size() != 0) chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!first_seen) begin
            first_seen = 1'b1;
            chk("latency", 32'((longint'($time) - sb[0].t_acc + 5) / 10), 32'(sb[0].lat));
          end
          chk("result", result, sb[0].res);
          chk("zero", 32'(zero), 32'(sb[0].zero));
          chk("illegal", 32'(illegal), 32'(sb[0].ill));
          if (out_ready) begin
            void'(sb.pop_front());
            first_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; alu_control = 4'd0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    align();

    // ADD, then in_ready back one cycle after the handshake
    send(4'd0, 32'd5, 32'd7);
    @(negedge clk);
    @(negedge clk);
    chk("add_in_ready_back", 32'(in_ready), 32'd1);
    align();

    send(4'd1, 32'h1234, 32'h1234);
    send(4'd8, 32'hFFFF_FFFF, 32'd1);
    send(4'd9, 32'hFFFF_FFFF, 32'd1);

    send(4'd7, 32'h8000_0000, 32'hFFFF_FF04);
    send(4'd5, 32'h0000_0001, 32'd31);
    send(4'd6, 32'h8000_0000, 32'd0);

    // Backpressure with a competing input held during the stall
    ordy_mode = 0;
    send(4'd0, 32'd1, 32'd1);
    fork
      begin
        send(4'd4, 32'd3, 32'd5);
        t4_done = 1'b1;
      end
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_result_held", result, 32'd2);
    end
    ordy_mode = 1;
    for (int i = 0; i < 50 && !t4_done; i++) @(posedge clk);
    chk("bp_second_accepted", 32'(t4_done), 32'd1);
    align();

    // Reset on the 10th shift edge of SLL by 20 discards the op
    send(4'd5, 32'h0000_0003, 32'd20);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_in_ready_back", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;

    send(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(4'd4, 32'hF0F0_F0F0, 32'h0F0F_0F0F);

    ordy_mode = 2;
    for (int i = 0; i < 250; i++) begin
      if (n_pass != n_chk) break;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = b;
      send(c, a, b);
    end

    ordy_mode = 1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
